// File: rtl/inst_fetch.sv
// inst_fetch: owns the fetch PC, drives the combinational instruction ROM and
// buffers returned words in a small prefetch FIFO that feeds decode.
// Optional misaligned-jump trap (HALT state, misalign_o): define INST_FETCH_MISALIGN_EXC_EN.
module inst_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        rom_ce_o,
  output logic [31:0] rom_addr_o,
  input  logic [31:0] rom_inst_i,
  input  logic        jump_flag_i,
  input  logic [31:0] jump_addr_i,
`ifdef INST_FETCH_MISALIGN_EXC_EN
  output logic        misalign_o,
`endif
  output logic [31:0] inst_o,
  output logic [31:0] inst_addr_o,
  output logic        inst_valid_o,
  input  logic        inst_ready_i
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH = CNT_W'(FIFO_DEPTH);

  if (!(FIFO_DEPTH == 2 || FIFO_DEPTH == 4)) begin : g_bad_depth
    $error("inst_fetch: FIFO_DEPTH must be 2 or 4");
  end
  if (RESET_PC[1:0] != 2'b00) begin : g_bad_reset_pc
    $error("inst_fetch: RESET_PC must be word aligned");
  end

`ifdef INST_FETCH_MISALIGN_EXC_EN
  typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;
`else
  typedef enum logic {BOOT, RUN} state_t;
`endif

  state_t state;
  state_t state_nxt;

  logic [31:0]      fetch_pc;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;
  logic [31:0]      inst_mem [FIFO_DEPTH];
  logic [31:0]      addr_mem [FIFO_DEPTH];

  logic        push;
  logic        pop;
  logic        head_valid;
  logic [31:0] jump_target;

  // Redirect target; without the trap the low address bits are dropped.
`ifdef INST_FETCH_MISALIGN_EXC_EN
  logic jump_misaligned;
  logic misalign;

  assign jump_misaligned = (jump_addr_i[1:0] != 2'b00);
  assign jump_target     = jump_addr_i;
  assign misalign_o      = misalign;
`else
  logic [1:0] unused_jump_lsb;

  assign unused_jump_lsb = jump_addr_i[1:0];
  assign jump_target     = {jump_addr_i[31:2], 2'b00};
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= BOOT;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      BOOT:    state_nxt = RUN;
      RUN:     state_nxt = RUN;
      default: state_nxt = state;
    endcase
`ifdef INST_FETCH_MISALIGN_EXC_EN
    if (jump_flag_i) begin
      state_nxt = jump_misaligned ? HALT : RUN;
    end
`endif
  end

  // Output logic: ROM request and FIFO handshake
  always_comb begin
    pop        = head_valid && inst_ready_i;
    push       = 1'b0;
    rom_ce_o   = 1'b0;
    rom_addr_o = 32'h0;
    if (state == RUN && !jump_flag_i && (count < DEPTH || pop)) begin
      push       = 1'b1;
      rom_ce_o   = 1'b1;
      rom_addr_o = fetch_pc;
    end
  end

  // Fetch PC and FIFO control; a jump flushes and drops any same-cycle pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else if (jump_flag_i) begin
      fetch_pc <= jump_target;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else begin
      if (push) begin
        fetch_pc <= fetch_pc + 32'd4;
        wr_ptr   <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

`ifdef INST_FETCH_MISALIGN_EXC_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      misalign <= 1'b0;
    end else if (jump_flag_i) begin
      misalign <= jump_misaligned;
    end
  end
`endif

  // Stage boundary: ROM word captured into the prefetch FIFO
  always_ff @(posedge clk) begin
    if (push) begin
      inst_mem[wr_ptr] <= rom_inst_i;
      addr_mem[wr_ptr] <= fetch_pc;
    end
  end

  assign head_valid   = (count != '0);
  assign inst_valid_o = head_valid;
  assign inst_o       = head_valid ? inst_mem[rd_ptr] : 32'h0;
  assign inst_addr_o  = head_valid ? addr_mem[rd_ptr] : 32'h0;

  a_rom_addr_aligned: assert property (@(posedge clk) disable iff (rst)
    rom_addr_o[1:0] == 2'b00);
  a_count_bounded: assert property (@(posedge clk) disable iff (rst)
    count <= DEPTH);
  a_ce_only_in_run: assert property (@(posedge clk) disable iff (rst)
    rom_ce_o |-> (state == RUN));

endmodule

// File: doc/inst_fetch.md
Name: inst_fetch

Overview:
- Fetch-side initiator for the combinational instruction ROM.
- Drives the ROM chip-enable and byte address, and captures the returned word into a small prefetch FIFO.
- Presents {instruction, address} to decode through a valid/ready handshake.
- Sits between the PC/jump logic of the core and the ROM. Owns the fetch PC, sequential increment, and flush on jump.

Parameters:
- RESET_PC, 32'h0000_0000, fetch address after reset; bits [1:0] must be 0.
- FIFO_DEPTH, 2, prefetch entries; legal values are 2 or 4.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous active-high reset.
- rom_ce_o  output  1  ROM chip enable (1 = enable, 0 = disable).
- rom_addr_o  output  32  ROM byte address; always word aligned.
- rom_inst_i  input  32  ROM read data, valid in the same cycle as rom_ce_o.
- jump_flag_i  input  1  redirect request from execute, one-cycle pulse.
- jump_addr_i  input  32  redirect target.
- inst_o  output  32  instruction at the FIFO head.
- inst_addr_o  output  32  address of inst_o.
- inst_valid_o  output  1  FIFO head valid.
- inst_ready_i  input  1  decode accepts the head.

Behaviour:
- Reset, asynchronous, rst=1:
  - fetch_pc=RESET_PC, FIFO empty (count=0, rd/wr pointers 0), state=BOOT.
  - Outputs: rom_ce_o=0, rom_addr_o=0, inst_o=0, inst_addr_o=0, inst_valid_o=0.
  - Reset asserted mid-operation discards all entries immediately.
- States: BOOT, RUN.
  - BOOT lasts exactly one cycle after rst deasserts, with no fetch, then goes to RUN.
  - RUN persists until reset.
- pop = inst_valid_o && inst_ready_i.
- push = RUN && !jump_flag_i && (count<FIFO_DEPTH || pop).
- rom_ce_o = push. This is combinational; it depends on inst_ready_i and jump_flag_i.
- rom_addr_o = fetch_pc when rom_ce_o=1, else 0.
- On push:
  - Write {rom_inst_i, fetch_pc} at wr_ptr.
  - fetch_pc += 4; the 32-bit add wraps from FFFF_FFFC to 0000_0000.
  - Pointers wrap modulo FIFO_DEPTH.
- Push and pop in the same cycle leave count unchanged; this is legal when full.
- Pop with the FIFO empty cannot occur, because valid is 0.
- Head outputs inst_o, inst_addr_o and inst_valid_o come straight from the FIFO head register (no combinational path from the ROM). Load-to-use latency is 1 cycle: a word fetched in cycle N is valid at N+1.
- When inst_valid_o=0, inst_o=0 and inst_addr_o=0.
- jump_flag_i=1 in RUN:
  - No push that cycle; any pop that cycle is ignored.
  - Next edge: FIFO flushed (count=0), fetch_pc={jump_addr_i[31:2],2'b00}.
  - First target word is fetched the cycle after the jump and is valid the cycle after that.
  - Back-to-back jumps: the last one wins.
- jump_flag_i in BOOT: fetch_pc is loaded with the jump target; the state still goes to RUN.
- rom_addr_o is never misaligned.
- Throughput: 1 instruction/cycle when decode is always ready.

Optional Feature:
- Macro: INST_FETCH_MISALIGN_EXC_EN.
- Enabled:
  - Adds port misalign_o (output, 1 bit) and state HALT.
  - jump_flag_i with jump_addr_i[1:0]!=0 flushes, sets misalign_o=1, loads fetch_pc with the raw target, and enters HALT.
  - HALT: no fetch (rom_ce_o=0). Leaves to RUN on an aligned jump, which also clears misalign_o. Misaligned jumps in HALT keep HALT.
  - misalign_o resets to 0.
- Disabled: jump_addr_i[1:0] are ignored (forced to 0); no HALT state, no misalign_o port.

Test Plan:
- Reset, ROM word[i]=i, ready=1 always -> rom_ce_o=0 for the first cycle after reset. Then inst_addr_o = 0,4,8,... with inst_o = 0,1,2,...; one instruction per cycle, first valid 2 cycles after reset release.
- ready=0 for 5 cycles from steady state -> count saturates at FIFO_DEPTH, rom_ce_o=0, fetch_pc frozen. On ready=1, addresses continue with no gap and no duplicate.
- Jump to 0x100 while the FIFO holds 2 entries -> entries discarded, no old address appears after the jump. Next addresses 0x100, 0x104; jump-cycle rom_ce_o=0.
- Jumps to 0x200 then 0x300 on consecutive cycles -> only 0x300 and onward delivered.
- fetch_pc=FFFF_FFF8 with ready=1 -> addresses FFFF_FFF8, FFFF_FFFC, 0000_0000.
- Macro on, jump to 0x102 -> misalign_o=1, rom_ce_o=0 until a jump to 0x40, then fetch resumes at 0x40 and misalign_o=0. Macro off, same stimulus -> fetch at 0x100.
